// File: rtl/udm_pkg.sv
// udm_pkg: shared constants and state types for the UART debug command decoder
package udm_pkg;
    localparam logic [7:0] SYNC_DEF = 8'h55;
    localparam logic [7:0] ESC_DEF  = 8'h5A;
    localparam logic [7:0] CMD_RST  = 8'h80;
    localparam logic [7:0] CMD_WR   = 8'h81;
    localparam logic [7:0] CMD_RD   = 8'h82;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_LEN, S_WDATA, S_RBURST} state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
endpackage

// File: rtl/udm_uart_rx.sv
// udm_uart_rx: 8N1 UART byte receiver with glitch rejection and framing check
// Build option: UDM_RX_PARITY_EN adds an even parity bit before the stop bit (8E1).
module udm_uart_rx
    import udm_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       stb_o,
    output logic       err_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    rx_state_t     state, state_nxt;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic          rx_s, tick, par_ok;
    assign rx_s = sync_q[1];
    assign tick = cnt == '0;
    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE:  state_nxt = rx_s ? R_IDLE : R_START;
            R_START: state_nxt = !tick ? R_START : rx_s ? R_IDLE : R_DATA;
`ifdef UDM_RX_PARITY_EN
            R_DATA:  state_nxt = (tick && bitn == 3'd7) ? R_PAR : R_DATA;
`else
            R_DATA:  state_nxt = (tick && bitn == 3'd7) ? R_STOP : R_DATA;
`endif
            R_PAR:   state_nxt = tick ? R_STOP : R_PAR;
            R_STOP:  state_nxt = tick ? R_IDLE : R_STOP;
            default: state_nxt = R_IDLE;
        endcase
    end
    // the counter idles preloaded with half a bit so the start bit is checked mid-bit
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state  <= R_IDLE;
            sync_q <= 2'b11;
            cnt    <= '0;
            bitn   <= '0;
            data_o <= '0;
            stb_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sync_q <= {sync_q[0], rx_i};
            cnt    <= (state == R_IDLE) ? HALF : tick ? FULL : cnt - CW'(1);
            bitn   <= (state == R_DATA) ? (tick ? bitn + 3'd1 : bitn) : 3'd0;
            data_o <= (state == R_DATA && tick) ? {rx_s, data_o[7:1]} : data_o;
            stb_o  <= state == R_STOP && tick && rx_s && par_ok;
            err_o  <= state == R_STOP && tick && !(rx_s && par_ok);
        end
    end
`ifdef UDM_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            par_ok <= 1'b1;
        else
            par_ok <= (state == R_START) ? 1'b1 : (state == R_PAR && tick) ? ~(^data_o ^ rx_s) : par_ok;
    end
`else
    assign par_ok = 1'b1;
`endif
endmodule

// File: rtl/udm_cmd_decoder.sv
// udm_cmd_decoder: UART debug frame parser driving a single-outstanding 32-bit bus master
// Build option: UDM_RX_PARITY_EN selects 8E1 reception in udm_uart_rx.
module udm_cmd_decoder
    import udm_pkg::*;
#(
    parameter int         CLK_DIV   = 868,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
    parameter logic [7:0] ESC_BYTE  = ESC_DEF
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        rx_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_resp_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    input  logic        rd_ready_i,
    output logic        bus_rst_o,
    output logic        err_o
);
    state_t      state, state_nxt;
    logic [7:0]  rx_byte;
    logic        rx_stb, rx_err;
    logic        esc, sync, dstb, last, wr_mode, rd_wait, drop;
    logic        bad_cmd, wr_done, wr_ok, rd_issue, rd_cap;
    logic [1:0]  idx;
    logic [31:0] sh, word;
    logic [29:0] cnt;

    udm_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .rx_i     (rx_i),
        .data_o   (rx_byte),
        .stb_o    (rx_stb),
        .err_o    (rx_err)
    );

    assign sync     = rx_stb && !esc && rx_byte == SYNC_BYTE;
    assign dstb     = rx_stb && (esc || (rx_byte != SYNC_BYTE && rx_byte != ESC_BYTE));
    assign word     = {rx_byte, sh[31:8]};
    assign last     = dstb && idx == 2'd3;
    assign bad_cmd  = state == S_CMD && dstb && rx_byte != CMD_RST && rx_byte != CMD_WR && rx_byte != CMD_RD;
    assign wr_done  = state == S_WDATA && last;
    assign wr_ok    = wr_done && !bus_req_o;
    assign rd_issue = state == S_RBURST && !sync && cnt != '0 && !bus_req_o && !rd_wait && !drop &&
                      (!rd_valid_o || rd_ready_i);
    assign rd_cap   = rd_wait && bus_resp_i && !drop;

    always_comb begin
        state_nxt = state;
        if (sync)
            state_nxt = S_CMD;
        else
            case (state)
                S_CMD:    state_nxt = !dstb ? S_CMD : (rx_byte == CMD_WR || rx_byte == CMD_RD) ? S_ADDR : S_IDLE;
                S_ADDR:   state_nxt = last ? S_LEN : S_ADDR;
                S_LEN:    state_nxt = !last ? S_LEN : word[31:2] == '0 ? S_IDLE : wr_mode ? S_WDATA : S_RBURST;
                S_WDATA:  state_nxt = (last && cnt == 30'd1) ? S_IDLE : S_WDATA;
                S_RBURST: state_nxt = (cnt == '0 && !bus_req_o && !rd_wait) ? S_IDLE : S_RBURST;
                default:  state_nxt = S_IDLE;
            endcase
    end

    // an aborted read still owes a response; drop swallows it so it never reaches rd_data_o
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= S_IDLE;
            esc         <= 1'b0;
            idx         <= '0;
            sh          <= '0;
            cnt         <= '0;
            wr_mode     <= 1'b0;
            rd_wait     <= 1'b0;
            drop        <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            bus_rst_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            esc         <= rx_stb ? (!esc && rx_byte == ESC_BYTE) : esc;
            idx         <= sync ? 2'd0 : (dstb && (state == S_ADDR || state == S_LEN || state == S_WDATA)) ? idx + 2'd1 : idx;
            sh          <= dstb ? word : sh;
            cnt         <= (state == S_LEN && last) ? word[31:2] : (wr_done || rd_issue) ? cnt - 30'd1 : cnt;
            wr_mode     <= (state == S_CMD && dstb) ? rx_byte == CMD_WR : wr_mode;
            bus_addr_o  <= (state == S_ADDR && last) ? {word[31:2], 2'b00} :
                           (bus_req_o && bus_ack_i) ? bus_addr_o + 32'd4 : bus_addr_o;
            bus_req_o   <= (rd_issue || wr_ok) ? 1'b1 : bus_ack_i ? 1'b0 : bus_req_o;
            bus_we_o    <= (rd_issue || wr_ok) ? wr_ok : bus_we_o;
            bus_wdata_o <= wr_ok ? word : bus_wdata_o;
            rd_wait     <= (bus_req_o && bus_ack_i && !bus_we_o) ? 1'b1 : bus_resp_i ? 1'b0 : rd_wait;
            drop        <= (sync && ((bus_req_o && !bus_we_o) || (rd_wait && !bus_resp_i))) ? 1'b1 :
                           (rd_wait && bus_resp_i) ? 1'b0 : drop;
            rd_valid_o  <= rd_cap ? 1'b1 : rd_ready_i ? 1'b0 : rd_valid_o;
            rd_data_o   <= rd_cap ? bus_rdata_i : rd_data_o;
            bus_rst_o   <= state == S_CMD && dstb && rx_byte == CMD_RST;
            err_o       <= sync ? 1'b0 : (rx_err || bad_cmd || (wr_done && bus_req_o)) ? 1'b1 : err_o;
        end
    end
endmodule

// File: tb/tb_udm_cmd_decoder.sv
// tb_udm_cmd_decoder: directed frame vectors against a simple acking bus responder
module tb_udm_cmd_decoder;
    localparam int DIV = 16;
    logic        clk = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        bus_req_o, bus_we_o, bus_ack_i = 1'b0, bus_resp_i = 1'b0;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i = '0, rd_data_o;
    logic        rd_valid_o, rd_ready_i = 1'b0, bus_rst_o, err_o;
    int          n_chk = 0, n_fail = 0, rst_pulses = 0, n0, p0;
    bit          ack_en = 1'b1;
    logic [31:0] log_addr[$], log_wdata[$];
    logic        log_we[$];

    udm_cmd_decoder #(.CLK_DIV(DIV)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n_i),
        .rx_i        (rx_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_resp_i  (bus_resp_i),
        .bus_rdata_i (bus_rdata_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_ready_i  (rd_ready_i),
        .bus_rst_o   (bus_rst_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_rst_o) rst_pulses++;

    // bus slave: acks one cycle after req is seen, read data (addr ^ 12345678) three cycles after ack
    initial begin
        int pend = 0;
        logic [31:0] rv = '0;
        forever begin
            @(negedge clk);
            bus_ack_i  = 1'b0;
            bus_resp_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus_resp_i  = 1'b1;
                    bus_rdata_i = rv;
                end
            end else if (ack_en && bus_req_o) begin
                bus_ack_i = 1'b1;
                log_addr.push_back(bus_addr_o);
                log_wdata.push_back(bus_wdata_o);
                log_we.push_back(bus_we_o);
                if (!bus_we_o) begin
                    pend = 3;
                    rv   = bus_addr_o ^ 32'h1234_5678;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok = 1'b1);
        rx_i = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UDM_RX_PARITY_EN
        rx_i = ^b;
        repeat (DIV) @(negedge clk);
`endif
        rx_i = !ok ? 1'b0 : 1'b1;
        repeat (10) @(negedge clk);
        rx_i = 1'b1;
        repeat (DIV - 10 + DIV) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] len);
        send_byte(8'h55);
        send_byte(cmd);
        send_word(addr);
        send_word(len);
    endtask

    task automatic wait_rdv();
        for (int i = 0; i < 200 && !rd_valid_o; i++) @(negedge clk);
        chk("rd_valid_wait", rd_valid_o, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", bus_req_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdv", rd_valid_o, 0);
        chk("rst_busrst", bus_rst_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        arst_n_i = 1'b1;
        repeat (20) @(negedge clk);

        // 1: single write
        n0 = log_addr.size();
        send_hdr(8'h81, 32'h8000_0000, 32'd4);
        send_word(32'hDEAD_BEEF);
        repeat (10) @(negedge clk);
        chk("wr_count", log_addr.size(), n0 + 1);
        chk("wr_we", log_we[n0], 1);
        chk("wr_addr", log_addr[n0], 32'h8000_0000);
        chk("wr_data", log_wdata[n0], 32'hDEAD_BEEF);
        chk("wr_addr_inc", bus_addr_o, 32'h8000_0004);
        chk("wr_err", err_o, 0);

        // 2: two-word read burst gated by rd_ready_i
        n0 = log_addr.size();
        send_hdr(8'h82, 32'h8000_0004, 32'd8);
        wait_rdv();
        chk("rd0_data", rd_data_o, 32'h9234_567C);
        repeat (20) @(negedge clk);
        chk("rd_hold_count", log_addr.size(), n0 + 1);
        chk("rd_hold_valid", rd_valid_o, 1);
        rd_ready_i = 1'b1;
        @(negedge clk);
        rd_ready_i = 1'b0;
        chk("rd_reissue", bus_req_o, 1);
        chk("rd_reissue_addr", bus_addr_o, 32'h8000_0008);
        wait_rdv();
        chk("rd1_data", rd_data_o, 32'h9234_5670);
        rd_ready_i = 1'b1;
        @(negedge clk);
        rd_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("rd_count", log_addr.size(), n0 + 2);
        chk("rd0_addr", log_addr[n0], 32'h8000_0004);
        chk("rd0_we", log_we[n0], 0);
        chk("rd1_addr", log_addr[n0 + 1], 32'h8000_0008);
        chk("rd_done_valid", rd_valid_o, 0);

        // 3: escaped payload
        n0 = log_addr.size();
        send_hdr(8'h81, 32'h0000_0100, 32'd4);
        send_byte(8'h5A); send_byte(8'h55); send_byte(8'h5A); send_byte(8'h5A);
        send_byte(8'h01); send_byte(8'h02);
        repeat (10) @(negedge clk);
        chk("esc_count", log_addr.size(), n0 + 1);
        chk("esc_addr", log_addr[n0], 32'h0000_0100);
        chk("esc_data", log_wdata[n0], 32'h0201_5A55);

        // 4: framing error, then SYNC aborting a write
        n0 = log_addr.size();
        send_byte(8'h3C, 1'b0);
        repeat (5) @(negedge clk);
        chk("frm_err", err_o, 1);
        chk("frm_noreq", bus_req_o, 0);
        send_hdr(8'h81, 32'h0000_0200, 32'd8);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h3C, 1'b0);
        chk("frm_err_mid", err_o, 1);
        send_byte(8'h55);
        chk("sync_clr_err", err_o, 0);
        send_byte(8'h81);
        send_word(32'h0000_0300);
        send_word(32'd4);
        send_word(32'h1122_3344);
        repeat (10) @(negedge clk);
        chk("abort_count", log_addr.size(), n0 + 1);
        chk("abort_addr", log_addr[n0], 32'h0000_0300);
        chk("abort_data", log_wdata[n0], 32'h1122_3344);

        // 5: overrun with ack withheld
        n0 = log_addr.size();
        ack_en = 1'b0;
        send_hdr(8'h81, 32'h0000_0400, 32'd8);
        send_word(32'hA4A3_A2A1);
        send_word(32'hB4B3_B2B1);
        repeat (10) @(negedge clk);
        chk("ovr_req", bus_req_o, 1);
        chk("ovr_we", bus_we_o, 1);
        chk("ovr_addr", bus_addr_o, 32'h0000_0400);
        chk("ovr_data", bus_wdata_o, 32'hA4A3_A2A1);
        chk("ovr_err", err_o, 1);
        ack_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovr_count", log_addr.size(), n0 + 1);
        chk("ovr_log_data", log_wdata[n0], 32'hA4A3_A2A1);
        chk("ovr_req_done", bus_req_o, 0);
        chk("ovr_addr_inc", bus_addr_o, 32'h0000_0404);

        // bus reset command and unknown command
        p0 = rst_pulses;
        send_byte(8'h55); send_byte(8'h80);
        repeat (5) @(negedge clk);
        chk("busrst_pulse", rst_pulses, p0 + 1);
        chk("busrst_err", err_o, 0);
        send_byte(8'h55); send_byte(8'h77);
        repeat (5) @(negedge clk);
        chk("badcmd_err", err_o, 1);

        // 6: async reset mid-ADDR, then a clean write that wraps the address
        n0 = log_addr.size();
        send_byte(8'h55); send_byte(8'h81); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h3C, 1'b0);
        chk("pre_rst_err", err_o, 1);
        arst_n_i = 1'b0;
        #1;
        chk("arst_err", err_o, 0);
        chk("arst_addr", bus_addr_o, 0);
        chk("arst_req", bus_req_o, 0);
        chk("arst_rdv", rd_valid_o, 0);
        repeat (4) @(negedge clk);
        arst_n_i = 1'b1;
        repeat (20) @(negedge clk);
        send_hdr(8'h81, 32'hFFFF_FFFC, 32'd4);
        send_word(32'h1234_5678);
        repeat (10) @(negedge clk);
        chk("post_rst_count", log_addr.size(), n0 + 1);
        chk("post_rst_addr", log_addr[n0], 32'hFFFF_FFFC);
        chk("post_rst_data", log_wdata[n0], 32'h1234_5678);
        chk("addr_wrap", bus_addr_o, 32'h0000_0000);
        chk("post_rst_err", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
